// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package mips_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        HOLD   = 2'd2,
        SQUASH = 2'd3
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mips_fetch_if.sv
// Instruction-memory request/acknowledge bus between fetch and memory.
interface mips_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_wait_timer.sv
// Saturating count of un-acked request cycles with a sticky timeout flag.
module fetch_wait_timer #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic active,
    input  logic clear,
    output logic imem_timeout
);

    localparam logic [15:0] LIMIT      = 16'(MAX_WAIT);
    localparam logic [15:0] LIMIT_LESS = 16'(MAX_WAIT - 1);

    logic [15:0] wait_cnt_reg;
    logic        timeout_reg;
    logic        tick;

    assign tick = active & ~clear;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            if (clear) begin
                wait_cnt_reg <= '0;
            end else if (tick && (wait_cnt_reg < LIMIT)) begin
                wait_cnt_reg <= wait_cnt_reg + 16'd1;
            end
            // The flag rises on the cycle whose increment reaches the limit.
            if (tick && (wait_cnt_reg >= LIMIT_LESS)) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign imem_timeout = timeout_reg;

endmodule

// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch stage: PC, imem handshake, redirect squashing, decode hand-off.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module mips_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic               clk,
    input  logic               reset_n,
    mips_fetch_if.master       imem,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_target,
    input  logic               decode_ready,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         opcode,
    output logic [31:0]        instr_pc,
    output logic [31:0]        pc_plus4,
    output logic               misaligned,
    output logic               imem_timeout,
    output logic [31:0]        fetch_count,
    output logic [31:0]        stall_count
);

    fetch_state_e       state_reg, state_next;
    logic [31:0]        pc_reg, pc_next;
    logic [31:0]        pend_reg, pend_next;
    logic [INSTR_W-1:0] instr_reg, instr_next;
    logic [31:0]        instr_pc_reg, instr_pc_next;
    logic [31:0]        pc_plus4_reg, pc_plus4_next;
    logic               valid_reg, valid_next;
    logic               misaligned_reg;

    logic               req_active;
    logic               ack_hit;
    logic [31:0]        target_aligned;
    logic [31:0]        pc_inc;

    // Request depends on the state register only, never on inputs.
    assign req_active     = (state_reg == REQ) || (state_reg == SQUASH);
    assign ack_hit        = req_active & imem.imem_ack;
    assign target_aligned = word_align(redirect_target);
    assign pc_inc         = pc_reg + 32'd4;

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        pend_next     = pend_reg;
        instr_next    = instr_reg;
        instr_pc_next = instr_pc_reg;
        pc_plus4_next = pc_plus4_reg;
        valid_next    = valid_reg;
        case (state_reg)
            IDLE: begin
                state_next = REQ;
                if (redirect_valid) pc_next = target_aligned;
            end
            REQ: begin
                if (redirect_valid) begin
                    if (ack_hit) begin
                        pc_next = target_aligned;
                    end else begin
                        pend_next  = target_aligned;
                        state_next = SQUASH;
                    end
                end else if (ack_hit) begin
                    instr_next    = imem.imem_rdata;
                    instr_pc_next = pc_reg;
                    pc_plus4_next = pc_inc;
                    pc_next       = pc_inc;
                    valid_next    = 1'b1;
                    state_next    = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_next    = target_aligned;
                    valid_next = 1'b0;
                    state_next = REQ;
                end else if (decode_ready) begin
                    valid_next = 1'b0;
                    state_next = REQ;
                end
            end
            SQUASH: begin
                // The address stays on the old PC until the stale word drains.
                if (redirect_valid) pend_next = target_aligned;
                if (ack_hit) begin
                    pc_next    = redirect_valid ? target_aligned : pend_reg;
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            pend_reg       <= '0;
            instr_reg      <= '0;
            instr_pc_reg   <= '0;
            pc_plus4_reg   <= '0;
            valid_reg      <= 1'b0;
            misaligned_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            pend_reg       <= pend_next;
            instr_reg      <= instr_next;
            instr_pc_reg   <= instr_pc_next;
            pc_plus4_reg   <= pc_plus4_next;
            valid_reg      <= valid_next;
            misaligned_reg <= redirect_valid && (redirect_target[1:0] != 2'b00);
        end
    end

    fetch_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .active       (req_active),
        .clear        (ack_hit | (state_next != state_reg)),
        .imem_timeout (imem_timeout)
    );

    assign imem.imem_req  = req_active;
    assign imem.imem_addr = pc_reg;
    assign instr_valid    = valid_reg;
    assign instr          = instr_reg;
    assign opcode         = instr_reg[OPC_MSB:OPC_LSB];
    assign instr_pc       = instr_pc_reg;
    assign pc_plus4       = pc_plus4_reg;
    assign misaligned     = misaligned_reg;

`ifdef FETCH_PERF_CNT_EN
    logic [1:0] cnt_inc;

    assign cnt_inc[0] = valid_reg & decode_ready & ~redirect_valid;
    assign cnt_inc[1] = valid_reg & ~decode_ready;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            logic [31:0] cnt_reg;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
        end
    endgenerate

    assign fetch_count = g_perf[0].cnt_reg;
    assign stall_count = g_perf[1].cnt_reg;
`else
    assign fetch_count = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Randomized bench for mips_fetch_unit against a transaction-level fetch model.
module tb_mips_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam int          MAXW   = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        decode_ready = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        misaligned;
    logic        imem_timeout;
    logic [31:0] fetch_count;
    logic [31:0] stall_count;

    mips_fetch_if bus ();

    mips_fetch_unit #(
        .RESET_PC (RST_PC),
        .MAX_WAIT (MAXW)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem            (bus),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .decode_ready    (decode_ready),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .opcode          (opcode),
        .instr_pc        (instr_pc),
        .pc_plus4        (pc_plus4),
        .misaligned      (misaligned),
        .imem_timeout    (imem_timeout),
        .fetch_count     (fetch_count),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: what the fetch stage is doing in transaction terms.
    bit          m_starting;   // first cycle after reset, no request yet
    bit          m_fetching;   // a request is outstanding
    bit          m_dropping;   // outstanding request's data will be thrown away
    bit          m_valid;
    bit          m_mis;
    bit          m_timeout;
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [31:0] m_fcnt;
    logic [31:0] m_scnt;
    int          m_wait;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == RST_PC) return 32'h8C08_0004;
        return ((addr ^ 32'h5A5A_1234) * 32'h0101_0101) + 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_starting = 1'b1;
        m_fetching = 1'b0;
        m_dropping = 1'b0;
        m_valid    = 1'b0;
        m_mis      = 1'b0;
        m_timeout  = 1'b0;
        m_pc       = RST_PC;
        m_pend     = '0;
        m_instr    = '0;
        m_ipc      = '0;
        m_fcnt     = '0;
        m_scnt     = '0;
        m_wait     = 0;
    endtask

    task automatic model_step(input bit rv, input logic [31:0] tgt, input bit ack, input bit rdy);
        logic [31:0] ta;
        bit          hit;
        ta  = tgt & 32'hFFFF_FFFC;
        hit = m_fetching && ack;
`ifdef FETCH_PERF_CNT_EN
        if (m_valid && rdy && !rv && m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
        if (m_valid && !rdy && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
`endif
        // Waiting cycles of one unbroken request phase.
        if (!m_fetching || hit || (rv && !m_dropping)) begin
            m_wait = 0;
        end else begin
            if (m_wait < MAXW) m_wait++;
            if (m_wait >= MAXW) m_timeout = 1'b1;
        end
        m_mis = rv && ((tgt & 32'h3) != 0);
        if (m_starting) begin
            m_starting = 1'b0;
            m_fetching = 1'b1;
            if (rv) m_pc = ta;
        end else if (!m_fetching) begin
            if (rv) m_pc = ta;
            if (rv || rdy) begin
                m_valid    = 1'b0;
                m_fetching = 1'b1;
            end
        end else if (m_dropping) begin
            if (rv) m_pend = ta;
            if (hit) begin
                m_pc       = m_pend;
                m_dropping = 1'b0;
            end
        end else if (rv) begin
            if (hit) m_pc = ta;
            else begin
                m_dropping = 1'b1;
                m_pend     = ta;
            end
        end else if (hit) begin
            m_instr    = mem_word(m_pc);
            m_ipc      = m_pc;
            m_pc       = m_pc + 32'd4;
            m_valid    = 1'b1;
            m_fetching = 1'b0;
            $display("fetch pc=%h instr=%h", m_ipc, m_instr);
        end
    endtask

    task automatic check_outputs();
        check_eq("imem_req", 32'(bus.imem_req), 32'(m_fetching));
        check_eq("imem_addr", bus.imem_addr, m_pc);
        check_eq("instr_valid", 32'(instr_valid), 32'(m_valid));
        if (m_valid) begin
            check_eq("instr", instr, m_instr);
            check_eq("opcode", 32'(opcode), m_instr >> 26);
            check_eq("instr_pc", instr_pc, m_ipc);
            check_eq("pc_plus4", pc_plus4, m_ipc + 32'd4);
        end
        check_eq("misaligned", 32'(misaligned), 32'(m_mis));
        check_eq("imem_timeout", 32'(imem_timeout), 32'(m_timeout));
        check_eq("fetch_count", fetch_count, m_fcnt);
        check_eq("stall_count", stall_count, m_scnt);
    endtask

    task automatic check_reset_zeros();
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_opcode", 32'(opcode), 32'h0);
        check_eq("rst_instr_pc", instr_pc, 32'h0);
        check_eq("rst_pc_plus4", pc_plus4, 32'h0);
    endtask

    // Drive one cycle of inputs at the falling edge, advance, then compare.
    task automatic cycle(input bit rv, input logic [31:0] tgt, input bit ack, input bit rdy);
        redirect_valid  = rv;
        redirect_target = tgt;
        decode_ready    = rdy;
        bus.imem_ack    = ack;
        bus.imem_rdata  = mem_word(bus.imem_addr);
        model_step(rv, tgt, ack, rdy);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        model_reset();
        #12;
        check_outputs();
        check_reset_zeros();
        @(negedge clk);
        reset_n = 1'b1;

        // First fetch from the reset vector, then a five-cycle decode stall.
        cycle(0, 0, 1, 1);
        cycle(0, 0, 1, 0);
        check_eq("first_opcode", 32'(opcode), 32'h23);
        check_eq("first_pc_plus4", pc_plus4, 32'h0040_0004);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0);
        check_eq("stall_instr", instr, 32'h8C08_0004);
`ifdef FETCH_PERF_CNT_EN
        check_eq("stall_count5", stall_count, 32'd5);
`endif
        for (int i = 0; i < 8; i++) cycle(0, 0, 1, 1);

        // Redirect while a request waits three cycles for its ack.
        cycle(0, 0, 0, 1);
        cycle(1, 32'h0000_1000, 0, 1);
        check_eq("squash_old_addr", bus.imem_addr, 32'h0040_0014);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 1);
        check_eq("squash_new_addr", bus.imem_addr, 32'h0000_1000);
        cycle(0, 0, 1, 1);
        check_eq("squash_instr_pc", instr_pc, 32'h0000_1000);

        // Misaligned redirect from HOLD.
        cycle(1, 32'h0000_1002, 0, 0);
        check_eq("mis_pulse", 32'(misaligned), 32'h1);
        check_eq("mis_addr", bus.imem_addr, 32'h0000_1000);
        cycle(0, 0, 1, 1);

        // Random traffic; ack is forced before the wait limit is reached.
        for (int i = 0; i < 400; i++) begin
            bit          rv;
            bit          ack;
            bit          rdy;
            logic [31:0] tgt;
            rv = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       tgt = $urandom;
                1:       tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                2:       tgt = 32'h0000_1000 | ($urandom & 32'h3);
                default: tgt = RST_PC + ($urandom & 32'hFC);
            endcase
            ack = ($urandom_range(0, 2) != 0) || (m_fetching && m_wait >= MAXW - 1);
            rdy = ($urandom_range(0, 3) != 0);
            cycle(rv, tgt, ack, rdy);
        end

        // Withhold ack from a fresh request until the timeout flag sets.
        for (int i = 0; i < 6 && !(m_valid && !m_fetching); i++) cycle(0, 0, 1, 0);
        check_eq("reach_hold", 32'(instr_valid), 32'h1);
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
        check_eq("timeout_before", 32'(imem_timeout), 32'h0);
        cycle(0, 0, 0, 1);
        check_eq("timeout_at_limit", 32'(imem_timeout), 32'h1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 1);
        cycle(0, 0, 0, 1);
        check_eq("timeout_sticky", 32'(imem_timeout), 32'h1);

        // Asynchronous reset during a stalled request; late ack afterwards.
        cycle(0, 0, 0, 1);
        #2;
        reset_n      = 1'b0;
        bus.imem_ack = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check_reset_zeros();
        @(negedge clk);
        check_outputs();
        reset_n = 1'b1;
        cycle(0, 0, 1, 1);
        cycle(0, 0, 1, 1);
        check_eq("post_reset_opcode", 32'(opcode), 32'h23);
        for (int i = 0; i < 20; i++) begin
            cycle(($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 1) == 1) || (m_fetching && m_wait >= MAXW - 1), ($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
